// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of control-word pipeline stages with per-stage stall/flush,
// forwarding selects and load-use detection. Optional counters: CTRL_PIPE_PERF_EN.
module ctrl_pipe_chain #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 3,
  parameter int RW_BIT = 5,
  parameter int MR_BIT = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        ctrlD,
  input  logic                    validD,
  input  logic [4:0]              dstD,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic [4:0]              srcA,
  input  logic [4:0]              srcB,
  output logic [STAGES*WIDTH-1:0] ctrl_q,
  output logic [STAGES-1:0]       valid_q,
  output logic [STAGES*5-1:0]     dst_q,
  output logic                    ready_in,
  output logic [STAGES-1:0]       fwdA,
  output logic [STAGES-1:0]       fwdB,
  output logic                    load_use
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]             bubble_cnt,
  output logic [31:0]             flush_cnt
`endif
);

  logic [WIDTH-1:0]  ctrlReg  [STAGES];
  logic [WIDTH-1:0]  ctrlNext [STAGES];
  logic [4:0]        dstReg   [STAGES];
  logic [4:0]        dstNext  [STAGES];
  logic [STAGES-1:0] validReg, validNext;
  logic [STAGES-1:0] hold, matchA, matchB, bubbleLoad;

  // An older stage holding forces every younger stage to hold as well.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) hold[k] = stall[k] | hold[k+1];
  end

  assign ready_in = ~hold[0];

  always_comb begin
    bubbleLoad = '0;
    validNext  = validReg;
    for (int k = 0; k < STAGES; k++) begin
      ctrlNext[k] = ctrlReg[k];
      dstNext[k]  = dstReg[k];
      if (flush[k]) begin
        ctrlNext[k]  = '0;
        validNext[k] = 1'b0;
        dstNext[k]   = '0;
      end else if (hold[k]) begin
        ctrlNext[k] = ctrlReg[k];
      end else if (k == 0) begin
        // Empty slots carry a zero control word so no enable leaks downstream.
        ctrlNext[k]  = validD ? ctrlD : '0;
        validNext[k] = validD;
        dstNext[k]   = dstD;
      end else if (hold[k-1]) begin
        ctrlNext[k]   = '0;
        validNext[k]  = 1'b0;
        dstNext[k]    = '0;
        bubbleLoad[k] = 1'b1;
      end else begin
        ctrlNext[k]  = ctrlReg[k-1];
        validNext[k] = validReg[k-1];
        dstNext[k]   = dstReg[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validReg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrlReg[k] <= '0;
        dstReg[k]  <= '0;
      end
    end else begin
      validReg <= validNext;
      for (int k = 0; k < STAGES; k++) begin
        ctrlReg[k] <= ctrlNext[k];
        dstReg[k]  <= dstNext[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign ctrl_q[gi*WIDTH +: WIDTH] = ctrlReg[gi];
      assign dst_q[gi*5 +: 5]          = dstReg[gi];
      assign matchA[gi] = validReg[gi] & ctrlReg[gi][RW_BIT] &
                          (dstReg[gi] != 5'd0) & (dstReg[gi] == srcA);
      assign matchB[gi] = validReg[gi] & ctrlReg[gi][RW_BIT] &
                          (dstReg[gi] != 5'd0) & (dstReg[gi] == srcB);
    end
  endgenerate

  assign valid_q = validReg;

  // Walk oldest to youngest so the youngest match is the one that survives.
  always_comb begin
    fwdA = '0;
    fwdB = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (matchA[k]) begin
        fwdA    = '0;
        fwdA[k] = 1'b1;
      end
      if (matchB[k]) begin
        fwdB    = '0;
        fwdB[k] = 1'b1;
      end
    end
  end

  assign load_use = (matchA[0] | matchB[0]) & ctrlReg[0][MR_BIT];

`ifdef CTRL_PIPE_PERF_EN
  logic bubbleEvent, flushEvent;
  assign bubbleEvent = |bubbleLoad;
  assign flushEvent  = |(flush & validReg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubbleEvent && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
      if (flushEvent && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain with default parameters (3 stages, 10-bit words).
module tb_ctrl_pipe_chain;
  localparam int W = 10;
  localparam int S = 3;

  logic           clk, rst;
  logic [W-1:0]   ctrlD;
  logic           validD;
  logic [4:0]     dstD;
  logic [S-1:0]   stall, flush;
  logic [4:0]     srcA, srcB;
  logic [S*W-1:0] ctrl_q;
  logic [S-1:0]   valid_q;
  logic [S*5-1:0] dst_q;
  logic           ready_in;
  logic [S-1:0]   fwdA, fwdB;
  logic           load_use;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]    bubble_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  ctrl_pipe_chain dut (
    .clk(clk), .rst(rst), .ctrlD(ctrlD), .validD(validD), .dstD(dstD),
    .stall(stall), .flush(flush), .srcA(srcA), .srcB(srcB),
    .ctrl_q(ctrl_q), .valid_q(valid_q), .dst_q(dst_q), .ready_in(ready_in),
    .fwdA(fwdA), .fwdB(fwdB), .load_use(load_use)
`ifdef CTRL_PIPE_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] c, input logic v, input logic [4:0] d);
    ctrlD = c; validD = v; dstD = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive('0, 1'b0, '0); stall = '0; flush = '0; srcA = '0; srcB = '0;
    edge1(); edge1();
    tests++; if (valid_q !== 3'b000) begin fails++; $display("FAIL reset_valid got %b want 000", valid_q); end
    tests++; if (ctrl_q !== '0) begin fails++; $display("FAIL reset_ctrl got %h want 0", ctrl_q); end
    tests++; if (dst_q !== '0) begin fails++; $display("FAIL reset_dst got %h want 0", dst_q); end
    tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_in); end
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      drive(W'(10'h3E0 + i), 1'b1, 5'(i + 1));
      edge1();
      $display("[TB] stream word %0d ctrl=%h valid_q=%b", i, ctrl_q, valid_q);
      if (i == 0) begin
        tests++; if (ctrl_q[0 +: W] !== 10'h3E0 || valid_q !== 3'b001) begin
          fails++; $display("FAIL stream_e1 got ctrl0=%h valid=%b want 3e0/001", ctrl_q[0 +: W], valid_q); end
      end
      if (i == 1) begin
        tests++; if (valid_q !== 3'b011) begin fails++; $display("FAIL stream_e2 got valid=%b want 011", valid_q); end
      end
      if (i == 2) begin
        tests++; if (ctrl_q[2*W +: W] !== 10'h3E0 || valid_q !== 3'b111 || dst_q[10 +: 5] !== 5'd1) begin
          fails++; $display("FAIL stream_e3 got ctrl2=%h valid=%b dst2=%0d want 3e0/111/1", ctrl_q[2*W +: W], valid_q, dst_q[10 +: 5]); end
      end
      if (i == 3) begin
        tests++; if (ctrl_q !== {10'h3E1, 10'h3E2, 10'h3E3} || valid_q !== 3'b111) begin
          fails++; $display("FAIL stream_e4 got ctrl=%h valid=%b want 3e1/3e2/3e3 111", ctrl_q, valid_q); end
      end
    end
  endtask

  task automatic test_stall();
    drive(10'h3E4, 1'b1, 5'd5);
    stall = 3'b010;
    #1;
    tests++; if (ready_in !== 1'b0) begin fails++; $display("FAIL stall_ready got %b want 0", ready_in); end
    for (int i = 0; i < 2; i++) begin
      edge1();
      $display("[TB] stall cycle %0d ctrl=%h valid_q=%b", i, ctrl_q, valid_q);
      tests++; if (ctrl_q !== {10'h000, 10'h3E2, 10'h3E3} || valid_q !== 3'b011) begin
        fails++; $display("FAIL stall_hold%0d got ctrl=%h valid=%b want 000/3e2/3e3 011", i, ctrl_q, valid_q); end
    end
    stall = 3'b000;
    edge1();
    tests++; if (ctrl_q !== {10'h3E2, 10'h3E3, 10'h3E4} || valid_q !== 3'b111) begin
      fails++; $display("FAIL stall_resume got ctrl=%h valid=%b want 3e2/3e3/3e4 111", ctrl_q, valid_q); end
    drive('0, 1'b0, '0);
    edge1();
    tests++; if (ctrl_q !== {10'h3E3, 10'h3E4, 10'h000} || valid_q !== 3'b110) begin
      fails++; $display("FAIL stall_drain got ctrl=%h valid=%b want 3e3/3e4/000 110", ctrl_q, valid_q); end
  endtask

  task automatic test_flush_stall();
    drive(10'h155, 1'b1, 5'd7);
    edge1();
    tests++; if (ctrl_q[0 +: W] !== 10'h155 || valid_q[0] !== 1'b1) begin
      fails++; $display("FAIL flush_load got ctrl0=%h v0=%b want 155/1", ctrl_q[0 +: W], valid_q[0]); end
    flush = 3'b001; stall = 3'b001;
    edge1();
    $display("[TB] flush+stall ctrl=%h valid_q=%b", ctrl_q, valid_q);
    tests++; if (valid_q[0] !== 1'b0 || ctrl_q[0 +: W] !== '0 || dst_q[0 +: 5] !== '0) begin
      fails++; $display("FAIL flush_wins got v0=%b ctrl0=%h dst0=%0d want 0/0/0", valid_q[0], ctrl_q[0 +: W], dst_q[0 +: 5]); end
`ifdef CTRL_PIPE_PERF_EN
    tests++; if (flush_cnt !== 32'd1) begin fails++; $display("FAIL flush_cnt got %0d want 1", flush_cnt); end
    tests++; if (bubble_cnt !== 32'd3) begin fails++; $display("FAIL bubble_cnt got %0d want 3", bubble_cnt); end
`endif
    flush = '0; stall = '0;
  endtask

  task automatic test_forward();
    srcA = 5'd5; srcB = 5'd0;
    drive(10'h020, 1'b1, 5'd5); edge1();
    drive(10'h020, 1'b1, 5'd5); edge1();
    tests++; if (fwdA !== 3'b001) begin fails++; $display("FAIL fwd_youngest got %b want 001", fwdA); end
    tests++; if (fwdB !== 3'b000) begin fails++; $display("FAIL fwd_b_zero got %b want 000", fwdB); end
    drive(10'h000, 1'b1, 5'd5); edge1();
    tests++; if (fwdA !== 3'b010) begin fails++; $display("FAIL fwd_rw_clear got %b want 010", fwdA); end
    drive(10'h000, 1'b1, 5'd5); edge1();
    tests++; if (fwdA !== 3'b100) begin fails++; $display("FAIL fwd_oldest got %b want 100", fwdA); end
    srcB = 5'd5; #1;
    tests++; if (fwdB !== 3'b100) begin fails++; $display("FAIL fwd_b_oldest got %b want 100", fwdB); end
    for (int i = 0; i < 3; i++) begin drive(10'h020, 1'b1, 5'd0); edge1(); end
    srcA = 5'd0; srcB = 5'd0; #1;
    tests++; if (fwdA !== 3'b000 || fwdB !== 3'b000) begin
      fails++; $display("FAIL fwd_reg0 got A=%b B=%b want 000/000", fwdA, fwdB); end
    srcA = 5'd5; #1;
    tests++; if (fwdA !== 3'b000) begin fails++; $display("FAIL fwd_nomatch got %b want 000", fwdA); end
    $display("[TB] forwarding checks done");
  endtask

  task automatic test_load_use();
    srcA = 5'd0; srcB = 5'd8;
    drive(10'h220, 1'b1, 5'd8); edge1();
    tests++; if (load_use !== 1'b1 || fwdB !== 3'b001) begin
      fails++; $display("FAIL lu_hit got lu=%b fwdB=%b want 1/001", load_use, fwdB); end
    srcB = 5'd9; #1;
    tests++; if (load_use !== 1'b0) begin fails++; $display("FAIL lu_other_reg got %b want 0", load_use); end
    srcB = 5'd8;
    drive(10'h220, 1'b0, 5'd8); edge1();
    tests++; if (load_use !== 1'b0 || ctrl_q[0 +: W] !== '0) begin
      fails++; $display("FAIL lu_invalid got lu=%b ctrl0=%h want 0/000", load_use, ctrl_q[0 +: W]); end
    $display("[TB] load-use checks done");
  endtask

  task automatic test_reset_mid();
    srcA = 5'd8; srcB = 5'd0;
    drive(10'h220, 1'b1, 5'd8); edge1();
    drive(10'h3FF, 1'b1, 5'd9); stall = 3'b100; #1;
    tests++; if (ready_in !== 1'b0) begin fails++; $display("FAIL last_stall_ready got %b want 0", ready_in); end
    edge1();
    tests++; if (ctrl_q[0 +: W] !== 10'h220 || load_use !== 1'b1) begin
      fails++; $display("FAIL last_stall_freeze got ctrl0=%h lu=%b want 220/1", ctrl_q[0 +: W], load_use); end
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset mid-stream valid_q=%b", valid_q);
    tests++; if (valid_q !== '0 || ctrl_q !== '0 || dst_q !== '0) begin
      fails++; $display("FAIL async_rst_state got v=%b c=%h d=%h want all 0", valid_q, ctrl_q, dst_q); end
    tests++; if (fwdA !== '0 || fwdB !== '0 || load_use !== 1'b0) begin
      fails++; $display("FAIL async_rst_hazard got A=%b B=%b lu=%b want 0", fwdA, fwdB, load_use); end
`ifdef CTRL_PIPE_PERF_EN
    tests++; if (bubble_cnt !== '0 || flush_cnt !== '0) begin
      fails++; $display("FAIL async_rst_perf got b=%0d f=%0d want 0", bubble_cnt, flush_cnt); end
`endif
    edge1();
    rst = 1'b0; stall = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_forward();
    test_load_use();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised control-word pipeline that generalises the fixed E/M/W control registers into a chain of STAGES registers, each with its own stall and flush. Each entry carries a control word, a valid bit and a 5-bit destination register. The block also produces forwarding-select and load-use hazard outputs from the carried fields. It sits between the main/ALU decoders and the datapath, and replaces the hand-written per-stage control flops.

Parameters:
WIDTH, 10, control-word width per stage
STAGES, 3, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W); legal range 2..8
RW_BIT, 5, index of the regwrite bit inside the control word
MR_BIT, 9, index of the memtoreg bit inside the control word

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ctrlD  in  WIDTH  control word from decode
validD  in  1  decode slot holds a real instruction
dstD  in  5  destination register from decode
stall  in  STAGES  per-stage hold request
flush  in  STAGES  per-stage clear request
srcA  in  5  decode-stage source register A (rs)
srcB  in  5  decode-stage source register B (rt)
ctrl_q  out  STAGES*WIDTH  stage k control word at [k*WIDTH +: WIDTH]
valid_q  out  STAGES  per-stage valid
dst_q  out  STAGES*5  stage k destination at [k*5 +: 5]
ready_in  out  1  stage 0 accepts decode this cycle
fwdA  out  STAGES  one-hot forwarding select for srcA; all-zero means register file
fwdB  out  STAGES  one-hot forwarding select for srcB; all-zero means register file
load_use  out  1  load-use hazard; decode must stall

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every ctrl_q, valid_q and dst_q bit is 0. Consequently fwdA, fwdB and load_use are also 0.
- Effective hold: h[STAGES-1] = stall[STAGES-1]; h[k] = stall[k] | h[k+1]. An older-stage stall therefore freezes every younger stage.
- ready_in = ~h[0].
- Per-stage update on each rising clk edge, in priority order:
  1. flush[k]=1: ctrl, valid and dst of stage k are cleared to 0. This overrides hold.
  2. h[k]=1: stage k keeps its contents.
  3. k=0: stage 0 loads {ctrlD, validD, dstD}.
  4. k>0 and h[k-1]=1: stage k loads a bubble (all zero).
  5. Otherwise stage k loads the contents of stage k-1.
- Latency: a word accepted at edge n appears in stage k after edge n+k, provided no stall or flush intervenes.
- A stage whose valid is 0 must present an all-zero ctrl word, so downstream logic never sees stale enables.
- Forwarding. Stage k matches srcX when all of the following hold:
  - valid_q[k]=1
  - ctrl[k][RW_BIT]=1
  - dst[k] != 0
  - dst[k] == srcX
  fwdX is one-hot on the lowest-indexed (youngest) matching stage. With no match, fwdX = 0. Register 0 never forwards.
- load_use = 1 when stage 0 matches srcA or srcB and ctrl[0][MR_BIT]=1.
- fwdX and load_use are purely combinational from the registered state and srcA/srcB. They are not affected by this cycle's stall or flush.
- Simultaneous flush[k] and stall[k]: the flush wins; the stage becomes empty.
- Stall on the last stage with stage STAGES-2 free: the whole chain freezes, because h propagates backward to every younger stage.

Optional Feature:
Macro: CTRL_PIPE_PERF_EN
- Defined: adds outputs bubble_cnt (32-bit) and flush_cnt (32-bit).
  - bubble_cnt increments once per cycle in which any stage k>0 loads a bubble under rule 4.
  - flush_cnt increments once per cycle in which any flush bit is 1 and the flushed stage had valid=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 asynchronously.
- Not defined: neither port nor either counter exists; all other behaviour is unchanged.

Test Plan:
- Reset release, then stream 4 valid words (ctrlD=10'h3E0..3E3, dst 1..4), no stall or flush -> word 10'h3E0 reaches stage 2 after exactly 3 edges. valid_q=3'b111 from the 3rd edge onward.
- Hold stall[1]=1 for 2 cycles with stage 0 and stage 1 full -> stages 0 and 1 frozen, ready_in=0, stage 2 receives bubbles (valid_q[2]=0, ctrl word 0). Release -> flow resumes with no word lost or duplicated.
- Assert flush[0] and stall[0] together with stage 0 valid -> next edge valid_q[0]=0 and ctrl word 0. With the perf macro defined, flush_cnt=1.
- Stage 0: dst=5, RW=1. Stage 1: dst=5, RW=1. srcA=5 -> fwdA=3'b001. Clear RW in stage 0 -> fwdA=3'b010. srcA=0 with dst=0 in every stage -> fwdA=0.
- Stage 0: MR=1, RW=1, dst=8; srcB=8 -> load_use=1. Same with srcB=9 -> load_use=0. Same with valid=0 -> load_use=0.
- Assert rst mid-stream while stalled -> every output is 0 immediately, before the next clk edge. Perf counters (if enabled) read 0.
